// File: rtl/burst_responder.sv
// burst_responder: target side of the start/size/data transfer interface.
// A one-cycle start with a non-zero word count opens a burst. Each word is accepted on
// data_valid && ready, written at the current address and queued in a small FIFO that a
// local consumer drains through rd_en/rd_data/rd_valid.
module burst_responder #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       ADDR_W     = 8,
    parameter int unsigned       SIZE_W     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       FIFO_DEPTH = 8,
    localparam int unsigned      LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    // initiator side
    input  logic              start,
    input  logic [SIZE_W-1:0] size,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              ready,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              done,
    output logic              err,
    // local consumer side
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [LVL_W-1:0]  level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
    localparam logic [SIZE_W-1:0] REM_ONE  = SIZE_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // ------------------------------------------------------------------
    // Burst control state
    // ------------------------------------------------------------------
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [SIZE_W-1:0] remaining_q, remaining_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // ------------------------------------------------------------------
    // Capture FIFO state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q;

    logic is_idle;
    logic is_active;
    logic accept;
    logic pop;
    logic start_ok;

    // Handshake decode shared by the FSM and the FIFO.
    always_comb begin
        is_idle   = (state_q == ST_IDLE);
        is_active = (state_q == ST_ACTIVE);
        // ready only depends on registered state, so it never loops through the initiator.
        ready     = is_active && (level_q < LVL_FULL);
        accept    = data_valid && ready;
        pop       = rd_en && (level_q != '0);
        start_ok  = is_idle && start && (size != '0);
    end

    // Burst FSM next state: start loads, each accept advances address and count.
    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d     = ST_ACTIVE;
                    remaining_d = size;
                    address_d   = BASE_ADDR;
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    // Natural overflow of the ADDR_W-bit add gives the required wrap.
                    address_d   = address_q + ADDR_ONE;
                    remaining_d = remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Protocol error detection; reported as a registered one-cycle pulse.
    always_comb begin
        err_d = 1'b0;
        if (is_idle) begin
            // Zero-length start, or a data word offered outside a burst. A start that
            // coincides with data_valid is still taken, but the word is dropped and flagged.
            if ((start && (size == '0)) || data_valid) begin
                err_d = 1'b1;
            end
        end else if (start) begin
            // A start during a burst is ignored; the burst carries on.
            err_d = 1'b1;
        end
    end

    // Burst control registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            address_q   <= BASE_ADDR;
            remaining_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // FIFO next state: pointers wrap on their own since the depth is a power of two.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_data_d = mem[rd_ptr_q];
        end

        unique case ({accept, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr_q] <= data;
        end
    end

    // FIFO pointers, occupancy and registered read port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= pop;
        end
    end

    // Registered outputs.
    always_comb begin
        address  = address_q;
        busy     = is_active;
        done     = done_q;
        err      = err_q;
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
        level    = level_q;
    end

endmodule

// File: tb/tb_burst_responder.sv
// Self-checking bench for burst_responder: directed scenarios plus a randomized run
// compared every cycle against a queue-based reference model.
module tb_burst_responder;

    localparam logic [7:0] BASE = 8'h10;
    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] size;
    logic [7:0] data;
    logic       data_valid;
    logic       ready;
    logic [7:0] address;
    logic       busy, done, err;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] level;

    // second instance: narrow address to exercise wrap
    logic       start2;
    logic [3:0] size2;
    logic [7:0] data2;
    logic       dv2;
    logic       ready2;
    logic [3:0] addr2;
    logic       busy2, done2, err2;
    logic       rd_en2;
    logic [7:0] rd_data2;
    logic       rd_valid2;
    logic [3:0] level2;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    burst_responder #(
        .DATA_W(8), .ADDR_W(8), .SIZE_W(4), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .size(size), .data(data),
        .data_valid(data_valid), .ready(ready), .address(address), .busy(busy),
        .done(done), .err(err), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .level(level)
    );

    burst_responder #(
        .DATA_W(8), .ADDR_W(4), .SIZE_W(4), .BASE_ADDR(4'hE), .FIFO_DEPTH(8)
    ) dut_wrap (
        .clock(clock), .reset(reset), .start(start2), .size(size2), .data(data2),
        .data_valid(dv2), .ready(ready2), .address(addr2), .busy(busy2),
        .done(done2), .err(err2), .rd_en(rd_en2), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .level(level2)
    );

    always #5 clock = ~clock;

    // Count done pulses; sampled at the edge, before the DUT updates.
    always @(posedge clock) if (done === 1'b1) done_cnt++;

    // ---------------- reference model (transaction level) ----------------
    bit         m_active;
    int         m_rem;
    int         m_addr;
    bit         m_done, m_err, m_rv;
    logic [7:0] m_rd;
    logic [7:0] m_q[$];
    bit         m_rdy, m_acc, m_pop;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 0; m_rem = 0; m_addr = int'(BASE);
            m_done = 0; m_err = 0; m_rv = 0; m_rd = 8'h00;
            m_q.delete();
        end else begin
            m_rdy = m_active && (m_q.size() < DEPTH);
            m_acc = (data_valid === 1'b1) && m_rdy;
            m_pop = (rd_en === 1'b1) && (m_q.size() > 0);
            if (!m_active) m_err = (start && size == 4'd0) || data_valid;
            else           m_err = start;
            m_done = 0;
            m_rv = m_pop;
            if (m_pop) m_rd = m_q.pop_front();
            if (m_acc) begin
                m_q.push_back(data);
                m_addr = (m_addr + 1) % 256;
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_active = 0; m_done = 1; end
            end else if (!m_active && start && size != 4'd0) begin
                m_active = 1; m_rem = int'(size); m_addr = int'(BASE);
            end
        end
    end

    // Stimulus helper only: empty the FIFO (bounded).
    task automatic drain();
        rd_en = 1'b1;
        for (int i = 0; i < 20 && level != 4'd0; i++) @(negedge clock);
        rd_en = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (address !== BASE) begin errors++; $display("FAIL reset_address: got %h want %h", address, BASE); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", ready); end
    endtask

    task automatic test_basic();
        logic [7:0] w;
        start = 1'b1; size = 4'd3;
        @(negedge clock);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            w = 8'hA1 + 8'(i);
            data = w; data_valid = 1'b1;
            checks++; if (address !== BASE + 8'(i)) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", i, address, BASE + 8'(i)); end
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready%0d: got %0b want 1", i, ready); end
            @(negedge clock);
        end
        data_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %0b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %0b want 0", busy); end
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL basic_level: got %0d want 3", level); end
        checks++; if (address !== BASE + 8'd3) begin errors++; $display("FAIL basic_addr_end: got %h want %h", address, BASE + 8'd3); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0b want 0", done); end
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            @(negedge clock);
            rd_en = 1'b0;
            w = 8'hA1 + 8'(i);
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rv%0d: got %0b want 1", i, rd_valid); end
            checks++; if (rd_data !== w) begin errors++; $display("FAIL basic_rd%0d: got %h want %h", i, rd_data, w); end
        end
        @(negedge clock);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rv_end: got %0b want 0", rd_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL basic_level_end: got %0d want 0", level); end
    endtask

    task automatic test_full();
        int c0;
        c0 = done_cnt;
        start = 1'b1; size = 4'd10;
        @(negedge clock);
        start = 1'b0; data_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data = 8'h30 + 8'(i);
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d: got %0b want 1", i, ready); end
            @(negedge clock);
        end
        data = 8'h38;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %0b want 0", ready); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level: got %0d want 8", level); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %0b want 1", busy); end
        @(negedge clock);
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_hold_level: got %0d want 8", level); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_hold_err: got %0b want 0", err); end
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        checks++; if (level !== 4'd7) begin errors++; $display("FAIL full_pop_level: got %0d want 7", level); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise: got %0b want 1", ready); end
        checks++; if (rd_data !== 8'h30) begin errors++; $display("FAIL full_rd0: got %h want 30", rd_data); end
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0; data = 8'h39;
        checks++; if (level !== 4'd7) begin errors++; $display("FAIL full_pushpop_level: got %0d want 7", level); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_early_done: got %0b want 0", done); end
        checks++; if (rd_data !== 8'h31) begin errors++; $display("FAIL full_rd1: got %h want 31", rd_data); end
        @(negedge clock);
        data_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %0b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %0b want 0", busy); end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level_end: got %0d want 8", level); end
        @(negedge clock);
        checks++; if (done_cnt - c0 !== 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt - c0); end
        drain();
    endtask

    task automatic test_addr_wrap();
        logic [3:0] ea;
        start2 = 1'b1; size2 = 4'd4;
        @(negedge clock);
        start2 = 1'b0; dv2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ea = 4'((14 + i) % 16);
            data2 = 8'(i);
            checks++; if (addr2 !== ea) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, addr2, ea); end
            @(negedge clock);
        end
        dv2 = 1'b0;
        checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL wrap_done: got %0b want 1", done2); end
        checks++; if (addr2 !== 4'h2) begin errors++; $display("FAIL wrap_addr_end: got %h want 2", addr2); end
        checks++; if (level2 !== 4'd4) begin errors++; $display("FAIL wrap_level: got %0d want 4", level2); end
    endtask

    task automatic test_errors();
        start = 1'b1; size = 4'd0;
        @(negedge clock);
        start = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_size0: got %0b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_size0_busy: got %0b want 0", busy); end
        @(negedge clock);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_size0_pulse: got %0b want 0", err); end
        data_valid = 1'b1; data = 8'h55;
        @(negedge clock);
        data_valid = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_idle_data: got %0b want 1", err); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL err_idle_level: got %0d want 0", level); end
        @(negedge clock);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_idle_pulse: got %0b want 0", err); end
        start = 1'b1; size = 4'd3;
        @(negedge clock);
        start = 1'b0; data_valid = 1'b1; data = 8'h61;
        @(negedge clock);
        data_valid = 1'b0; start = 1'b1; size = 4'd7;
        @(negedge clock);
        start = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_active_start: got %0b want 1", err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_active_busy: got %0b want 1", busy); end
        checks++; if (address !== BASE + 8'd1) begin errors++; $display("FAIL err_active_addr: got %h want %h", address, BASE + 8'd1); end
        @(negedge clock);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_active_pulse: got %0b want 0", err); end
        data_valid = 1'b1; data = 8'h62;
        @(negedge clock);
        data = 8'h63;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL err_rem_early: got %0b want 0", done); end
        @(negedge clock);
        data_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL err_rem_done: got %0b want 1", done); end
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL err_rem_level: got %0d want 3", level); end
        drain();
    endtask

    task automatic test_reset_mid();
        start = 1'b1; size = 4'd5;
        @(negedge clock);
        start = 1'b0; data_valid = 1'b1; data = 8'h71;
        @(negedge clock);
        data = 8'h72; rd_en = 1'b1;
        @(negedge clock);
        data_valid = 1'b0; rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_rv: got %0b want 1", rd_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b want 0", busy); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rmid_level: got %0d want 0", level); end
        checks++; if (address !== BASE) begin errors++; $display("FAIL rmid_addr: got %h want %h", address, BASE); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_rv: got %0b want 0", rd_valid); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %0b want 0", ready); end
        @(negedge clock);
        reset = 1'b0;
        start = 1'b1; size = 4'd1;
        @(negedge clock);
        start = 1'b0; data_valid = 1'b1; data = 8'h7A;
        checks++; if (address !== BASE) begin errors++; $display("FAIL rmid_new_addr: got %h want %h", address, BASE); end
        @(negedge clock);
        data_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_done: got %0b want 1", done); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL rmid_new_level: got %0d want 1", level); end
        drain();
    endtask

    task automatic test_fifo_edges();
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_rv: got %0b want 0", rd_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL empty_pop_err: got %0b want 0", err); end
        start = 1'b1; size = 4'd8;
        @(negedge clock);
        start = 1'b0; data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = 8'h80 + 8'(i);
            @(negedge clock);
        end
        checks++; if (level !== 4'd4) begin errors++; $display("FAIL pp_pre_level: got %0d want 4", level); end
        data = 8'h84; rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        checks++; if (level !== 4'd4) begin errors++; $display("FAIL pp_level: got %0d want 4", level); end
        checks++; if (rd_data !== 8'h80) begin errors++; $display("FAIL pp_rd: got %h want 80", rd_data); end
        for (int i = 0; i < 3; i++) begin
            data = 8'h85 + 8'(i);
            @(negedge clock);
        end
        data_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pp_done: got %0b want 1", done); end
        checks++; if (level !== 4'd7) begin errors++; $display("FAIL pp_level_end: got %0d want 7", level); end
        drain();
    endtask

    task automatic test_random();
        logic       e_rdy;
        logic [7:0] e_addr;
        for (int c = 0; c < 3000; c++) begin
            e_rdy  = m_active && (m_q.size() < DEPTH);
            e_addr = 8'(m_addr);
            checks++; if (ready !== e_rdy) begin errors++; $display("FAIL rnd_ready@%0d: got %0b want %0b", c, ready, e_rdy); end
            checks++; if (address !== e_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", c, address, e_addr); end
            checks++; if (busy !== m_active) begin errors++; $display("FAIL rnd_busy@%0d: got %0b want %0b", c, busy, m_active); end
            checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done@%0d: got %0b want %0b", c, done, m_done); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %0b want %0b", c, err, m_err); end
            checks++; if (rd_valid !== m_rv) begin errors++; $display("FAIL rnd_rv@%0d: got %0b want %0b", c, rd_valid, m_rv); end
            checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL rnd_rd@%0d: got %h want %h", c, rd_data, m_rd); end
            checks++; if (level !== 4'(m_q.size())) begin errors++; $display("FAIL rnd_level@%0d: got %0d want %0d", c, level, m_q.size()); end
            start      = ($urandom_range(0, 9) == 0);
            size       = 4'($urandom_range(0, 15));
            data       = 8'($urandom);
            data_valid = ($urandom_range(0, 9) < 7);
            rd_en      = ($urandom_range(0, 9) < 4);
            @(negedge clock);
        end
        start = 1'b0; data_valid = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; size = 4'd0; data = 8'h00; data_valid = 1'b0; rd_en = 1'b0;
        start2 = 1'b0; size2 = 4'd0; data2 = 8'h00; dv2 = 1'b0; rd_en2 = 1'b0;
        repeat (2) @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_basic();
        test_full();
        test_addr_wrap();
        test_errors();
        test_reset_mid();
        test_fifo_edges();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/burst_responder.md
Name: burst_responder

Overview:
Target-side (responder) end of the start/size/data clocking-block transfer interface driven by a test-controller module. Accepts a one-cycle start with a word count, then captures that many data words with a valid/ready handshake. Drives the address each word is written to back to the initiator, and buffers the words in an internal FIFO for a local consumer. Sits behind the interface instance, in the same single clock domain as the initiator's clocking block.

Parameters:
DATA_W, 8, width of data and rd_data
ADDR_W, 8, width of address; address arithmetic is modulo 2^ADDR_W
SIZE_W, 4, width of size (max burst 2^SIZE_W-1 words)
BASE_ADDR, 0, address loaded on every accepted start
FIFO_DEPTH, 8, capture FIFO depth; power of two, >=2

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  burst request, sampled only in IDLE
size  input  SIZE_W  burst length in words, sampled with start
data  input  DATA_W  write word
data_valid  input  1  data is valid this cycle
ready  output  1  responder accepts data this cycle
address  output  ADDR_W  address of the word accepted this cycle
busy  output  1  high in ACTIVE
done  output  1  one-cycle pulse after the last word of a burst is accepted
err  output  1  one-cycle protocol-error pulse
rd_en  input  1  consumer pop request
rd_data  output  DATA_W  popped word, registered
rd_valid  output  1  rd_data valid, one cycle after a successful pop
level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, any cycle, including mid-burst): state IDLE; address=BASE_ADDR; remaining=0; FIFO emptied with level=0. Outputs: busy=0, done=0, err=0, rd_valid=0, rd_data=0.
- States: IDLE, ACTIVE.
- IDLE:
  - start=1 and size!=0: load remaining=size and address=BASE_ADDR; go to ACTIVE next cycle.
  - start=1 and size==0: err=1 next cycle; stay IDLE.
  - data_valid=1 without start: word ignored, err=1 next cycle.
  - start and data_valid in the same cycle: start accepted, data dropped, err=1 next cycle.
- ACTIVE:
  - ready = (state==ACTIVE) && (level<FIFO_DEPTH). ready is combinational and is 0 in IDLE.
  - Accept occurs on data_valid && ready. On accept:
    - data is pushed to the FIFO;
    - address increments next cycle, wrapping 2^ADDR_W-1 to 0;
    - remaining decrements.
  - An accept with remaining==1 completes the burst: next cycle state is IDLE, done=1, busy=0. address then holds last+1 until the next start.
  - data_valid while ready=0 (FIFO full): no accept, no err. The initiator holds the word.
  - start=1 in ACTIVE: ignored, err=1 next cycle, burst continues unaffected.
- busy and address are registered. address always reflects the address of the word the next accept will write.
- FIFO:
  - Pop occurs when rd_en && level>0. rd_data is loaded and rd_valid=1 on the next cycle; otherwise rd_valid=0 and rd_data holds its value.
  - rd_en on empty: ignored, no err.
  - Simultaneous push and pop: level unchanged. At full, a same-cycle pop does not enable a push, because ready was already 0; ready rises the cycle after.
  - Pointers wrap modulo FIFO_DEPTH. level ranges 0..FIFO_DEPTH.
- A new start is accepted no earlier than the cycle done is high, since the FSM is already in IDLE then.

Test Plan:
- Reset, then start=1 with size=3 and BASE_ADDR=0x10. Drive data 0xA1, 0xA2, 0xA3 with data_valid held high -> address reads 0x10, 0x11, 0x12 at the accepts; done pulses one cycle after 0xA3; level=3. Popping three times yields 0xA1, 0xA2, 0xA3, each with rd_valid one cycle after rd_en.
- FIFO_DEPTH=8, size=10, no pops -> ready drops after 8 accepts with level=8 and busy=1. A single rd_en makes ready rise the next cycle; the burst finishes after two more accepts; done=1 occurs once.
- ADDR_W=4, BASE_ADDR=0xE, size=4 -> addresses 0xE, 0xF, 0x0, 0x1.
- Protocol errors, each produces exactly one err pulse with no state change:
  - start with size=0 in IDLE;
  - data_valid in IDLE (word not stored, level stays 0);
  - start during ACTIVE (remaining unchanged).
- Assert reset mid-burst after 2 of 5 words -> busy=0, level=0, address=BASE_ADDR, rd_valid=0 immediately. A subsequent start with size=1 completes normally.
- rd_en on empty FIFO -> rd_valid stays 0. Push and pop in the same cycle at level=4 -> level stays 4.
